fifo_read_arbiter: RTL and testbench
====================================

# fifo_read_arbiter

Round-robin arbiter that shares the read port of the asynchronous FIFO among NUM_REQ consumers in the read-clock domain. It grants one requester at a time for a burst of up to BURST_LEN words. It drives `r_en` only while the FIFO is non-empty and returns each word tagged with the requester index. A starvation counter releases the grant when the FIFO stays empty too long, so one idle burst cannot block the other consumers.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `DATA_WIDTH`, 8: FIFO word width.
- `BURST_LEN`, 4: maximum reads per grant, at least 1.
- `STARVE_LIMIT`, 8: consecutive empty cycles during a burst before the grant is released, at least 1.
- `ID_W`, `$clog2(NUM_REQ)`: width of `out_id` (local parameter).

Ports:
- `r_clk`  in  1: read-domain clock; all logic runs on its rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req`  in  NUM_REQ: per-requester read request, level-sensitive.
- `r_empty`  in  1: FIFO empty flag, valid in the current cycle.
- `r_data`  in  DATA_WIDTH: FIFO read data, valid the cycle after `r_en`.
- `r_en`  out  1: FIFO read enable.
- `grant`  out  NUM_REQ: one-hot current owner; all zeros when idle.
- `out_valid`  out  1: `out_data`/`out_id` carry a word this cycle.
- `out_data`  out  DATA_WIDTH: word read from the FIFO.
- `out_id`  out  ID_W: index of the requester that owns `out_data`.
- `burst_done`  out  1: single-cycle pulse when a grant ends.

## Operation
- FSM states: IDLE, BURST, RELEASE. `state`, `grant`, `cnt`, `starve`, `last` and all outputs except `r_en` are registered.
- Reset values:
  - State IDLE; `grant`=0, `r_en`=0, `out_valid`=0, `out_data`=0, `out_id`=0, `burst_done`=0, `cnt`=0, `starve`=0.
  - `last`=NUM_REQ-1, so requester 0 has top priority after reset.
- IDLE:
  - If `req`≠0, select the first set bit searching upward from index (`last`+1) mod NUM_REQ, with wrap-around.
  - Next cycle: `grant`=one-hot of the selected index, `cnt`=BURST_LEN, `starve`=0, state BURST.
  - If `req`=0, stay in IDLE.
- BURST:
  - `r_en` = !`r_empty` & (`cnt`≠0) & `req`[owner]. This is combinational, and `r_en` is never high while `r_empty`=1.
  - On each `r_en`: `cnt` decrements and `starve` clears.
  - On each cycle with `r_empty`=1: `starve` increments and saturates at STARVE_LIMIT.
  - Go to RELEASE on the first cycle in which any exit condition holds:
    - `r_en`=1 with `cnt`=1 (last word of the burst);
    - `req`[owner]=0 (early abort; no `r_en` that cycle);
    - `starve` reaches STARVE_LIMIT.
- RELEASE (one cycle):
  - `r_en`=0 and `grant` is still held.
  - `burst_done`=1 in this cycle.
  - `last` ← owner index.
  - Next cycle: `grant`=0, state IDLE.
- Data return:
  - The cycle after every `r_en`: `out_valid`=1, `out_data`=`r_data`, `out_id`=owner index.
  - `out_data`/`out_id` hold their values when `out_valid`=0.
  - Consumers must accept every word; there is no backpressure.
- Width rules:
  - `cnt` is `$clog2(BURST_LEN+1)` bits.
  - `starve` is `$clog2(STARVE_LIMIT+1)` bits.
  - The round-robin index is computed mod NUM_REQ.

## Timing
- Request to grant: 1 cycle (`req` seen in IDLE at cycle t, `grant` valid at t+1).
- Grant to first `r_en`: 0 cycles. `r_en` can be high at t+1 if the FIFO is non-empty.
- `r_en` to `out_valid`: 1 cycle.
- Burst end to next grant:
  - RELEASE occupies 1 cycle and IDLE occupies 1 cycle.
  - Back-to-back bursts therefore have a 2-cycle gap with `r_en`=0.
- Full uninterrupted burst: BURST_LEN consecutive `r_en` cycles.
- Simultaneous events:
  - Last read together with `req` dropping: the read still counts as the last word.
  - `starve` reaching its limit in the same cycle: RELEASE, entered once.
- `req`[owner] falling while `r_empty`=1: abort takes priority, giving RELEASE next cycle.
- Reset in any state:
  - Takes effect at the next edge and forces `r_en`=0 that cycle.
  - A word read in the cycle before reset is discarded (`out_valid` is forced to 0).

## Test plan
- Single requester, `req`=0001, FIFO holds 6 words, BURST_LEN=4:
  - 4 `r_en` pulses, then `out_valid` ×4 with `out_id`=0, then `burst_done`.
  - After a 2-cycle gap, a new grant to requester 0 reads the remaining 2 words.
- `req`=1111 held with the FIFO always full:
  - Grants rotate 0→1→2→3→0, each for 4 reads.
  - `out_id` sequence matches.
  - `grant` is never multi-hot.
- FIFO empty after a grant to requester 2:
  - `r_en` stays 0.
  - After 8 empty cycles, RELEASE and `burst_done`; the next grant goes to requester 3 if it is requesting.
- `req`[1] drops after 2 reads:
  - No third `r_en`; exactly 2 `out_valid` with `out_id`=1.
  - RELEASE next cycle, and the pointer advances.
- `r_empty` toggles 1,0,1,0 during a burst: `r_en` asserts only in non-empty cycles, `starve` clears on each read, and the burst completes with 4 words.
- `rst` asserted mid-burst after an `r_en`:
  - Next cycle: all outputs at reset values and `out_valid`=0.
  - Request priority restarts at requester 0.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//
// Purpose:
//   Shares the read port of an asynchronous FIFO among NUM_REQ consumers in
//   the read-clock domain. A round-robin pointer picks one requester at a
//   time. The owner may read up to BURST_LEN words. Each returned word is
//   tagged with the owner's index. If the FIFO stays empty for STARVE_LIMIT
//   consecutive cycles during a burst, the grant is released so that an
//   idle burst cannot lock out the other consumers.
//
// Ports:
//   r_clk      in   read-domain clock, rising edge
//   rst        in   synchronous reset, active-high
//   req        in   [NUM_REQ-1:0] level-sensitive read requests
//   r_empty    in   FIFO empty flag for the current cycle
//   r_data     in   [DATA_WIDTH-1:0] FIFO data, valid the cycle after r_en
//   r_en       out  FIFO read enable (combinational)
//   grant      out  [NUM_REQ-1:0] one-hot owner, zero when idle
//   out_valid  out  out_data/out_id carry a word this cycle
//   out_data   out  [DATA_WIDTH-1:0] word read from the FIFO
//   out_id     out  [ID_W-1:0] requester index that owns out_data
//   burst_done out  one-cycle pulse while a grant is being released
module fifo_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  burst_done
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_W-1:0]       owner;
  logic [ID_W-1:0]       last;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [STV_W-1:0]      starve;
  logic [STV_W-1:0]      starve_nxt;
  logic [DATA_WIDTH-1:0] data_hold;
  logic                  sel_found;
  logic [ID_W-1:0]       sel_idx;
  int                    rr_idx;
  logic                  owner_req;
  logic                  last_word;
  logic                  starved;

  // Round-robin search. Walking the offsets from the farthest back to the
  // nearest lets the requester closest to (last+1) overwrite any earlier
  // hit, so the first set bit in wrap-around order wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_idx = (int'(last) + 1 + k) % NUM_REQ;
      if (req[rr_idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(rr_idx);
      end
    end
  end

  // The FIFO is read straight from the current empty flag so that a burst
  // can start in the same cycle the grant appears. Reset also masks the
  // enable so that no word is popped and then thrown away by the reset.
  assign owner_req = req[owner];
  assign r_en      = (state == BURST) && !rst && !r_empty &&
                     (cnt != '0) && owner_req;

  // Next-state logic. The read counter and the starvation counter are
  // updated here. Starvation is judged on the updated value, so the grant
  // is dropped in the cycle that completes STARVE_LIMIT empty cycles.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    starve_nxt = starve;
    last_word  = 1'b0;
    starved    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt  = BURST;
          cnt_nxt    = CNT_W'(BURST_LEN);
          starve_nxt = '0;
        end
      end
      BURST: begin
        if (r_en) begin
          cnt_nxt    = cnt - CNT_W'(1);
          starve_nxt = '0;
        end else if (r_empty) begin
          if (starve != STV_W'(STARVE_LIMIT)) begin
            starve_nxt = starve + STV_W'(1);
          end
        end
        last_word = r_en && (cnt == CNT_W'(1));
        starved   = (starve_nxt == STV_W'(STARVE_LIMIT));
        if (last_word || !owner_req || starved) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and output registers. The grant is held through RELEASE
  // and cleared when the FSM moves back to IDLE. The round-robin pointer
  // moves to the owner at that point, so the owner gets lowest priority
  // next time. It resets to NUM_REQ-1 so that requester 0 wins first.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last       <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      starve     <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      data_hold  <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      starve     <= starve_nxt;
      burst_done <= (state == BURST) && (state_nxt == RELEASE);
      if (state == IDLE && sel_found) begin
        grant <= NUM_REQ'(1) << sel_idx;
        owner <= sel_idx;
      end
      if (state == RELEASE) begin
        grant <= '0;
        last  <= owner;
      end
      out_valid <= r_en;
      if (r_en) begin
        out_id <= owner;
      end
      if (out_valid) begin
        data_hold <= r_data;
      end
    end
  end

  // The FIFO presents its word one cycle after r_en, which is the cycle in
  // which out_valid is high. That word is passed straight through and also
  // captured, so out_data holds its value while out_valid is low.
  assign out_data = out_valid ? r_data : data_hold;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter
//
// Purpose:
//   Directed bench for fifo_read_arbiter with the default parameters
//   (4 requesters, 8-bit data, bursts of 4, starvation limit 8). A small
//   FIFO model feeds the DUT. The stimulus process queues the (id, data)
//   pairs it expects to come back. A monitor pops that queue whenever
//   out_valid is high and checks the grant encoding every cycle.
module tb_fifo_read_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic                  r_clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic [NUM_REQ-1:0]    grant;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_id;
  logic                  burst_done;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rd_count = 0;
  int   last_rd_cyc = 0;
  int   wptr = 0;
  int   rptr = 0;
  int   mark = 0;
  int   gcyc = 0;
  logic force_empty;
  logic mon_en = 1'b0;
  logic [7:0] fifo_mem [0:63];
  exp_t exp_q [$];

  fifo_read_arbiter #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (8),
    .BURST_LEN   (4),
    .STARVE_LIMIT(8)
  ) dut (
    .r_clk     (r_clk),
    .rst       (rst),
    .req       (req),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .r_en      (r_en),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .burst_done(burst_done)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: registered read data, with an empty flag that can also be
  // forced high to emulate a write side that has not caught up yet.
  assign r_empty = force_empty || (rptr == wptr);

  always @(posedge r_clk) begin
    if (r_en) begin
      r_data <= fifo_mem[rptr];
      rptr   <= rptr + 1;
    end
  end

  // Cycle counter plus a count of reads and the cycle of the latest read.
  always @(posedge r_clk) begin
    if (r_en) begin
      rd_count    = rd_count + 1;
      last_rd_cyc = cyc;
    end
    cyc = cyc + 1;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: scoreboard on out_valid, plus per-cycle structural checks.
  always @(negedge r_clk) begin
    exp_t e;
    if (mon_en) begin
      check_output("grant_onehot0", int'($onehot0(grant)), 1);
      check_output("r_en_while_empty", int'(r_en && r_empty), 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("out_id", int'(out_id), int'(e.id));
          check_output("out_data", int'(out_data), int'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NUM_REQ-1:0] r, input logic fe);
    req         = r;
    force_empty = fe;
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_mem[wptr] = d;
    wptr = wptr + 1;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Advance at least one cycle, then until a grant is visible.
  task automatic wait_grant(input logic [NUM_REQ-1:0] expected, input int bound);
    int n;
    n = 0;
    step();
    while (grant == '0 && n < bound) begin
      step();
      n++;
    end
    check_output("grant", int'(grant), int'(expected));
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (burst_done !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check_output("burst_done_seen", int'(burst_done === 1'b1), 1);
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus('0, 1'b0);
    reset_dut();
    mon_en = 1'b1;

    // Reset values.
    check_output("rst_grant", int'(grant), 0);
    check_output("rst_r_en", int'(r_en), 0);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_out_data", int'(out_data), 0);
    check_output("rst_out_id", int'(out_id), 0);
    check_output("rst_burst_done", int'(burst_done), 0);

    // Single requester, six words: a burst of 4, a 2-cycle gap, then 2 more.
    for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) push_exp(2'd0, 8'hA0 + 8'(i));
    rd_count = 0;
    apply_stimulus(4'b0001, 1'b0);
    wait_grant(4'b0001, 5);
    wait_done(10);
    check_output("t1_reads_burst1", rd_count, 4);
    wait_grant(4'b0001, 5);
    check_output("t1_r_en_at_grant", int'(r_en), 1);
    check_output("t1_gap", cyc - last_rd_cyc, 3);
    wait_done(20);
    check_output("t1_reads_total", rd_count, 6);
    apply_stimulus('0, 1'b0);
    step();

    // All four requesting with a full FIFO: grants rotate 0,1,2,3.
    reset_dut();
    rd_count = 0;
    for (int i = 0; i < 16; i++) push_word(8'hB0 + 8'(i));
    for (int i = 0; i < 16; i++) push_exp(2'(i / 4), 8'hB0 + 8'(i));
    apply_stimulus(4'b1111, 1'b0);
    for (int g = 0; g < 4; g++) begin
      wait_grant(4'(1 << g), 5);
      wait_done(10);
    end
    apply_stimulus('0, 1'b0);
    check_output("t2_reads", rd_count, 16);
    step();

    // Empty FIFO with requester 2 granted: starvation release after 8 cycles.
    mark = rd_count;
    apply_stimulus(4'b0100, 1'b0);
    wait_grant(4'b0100, 5);
    gcyc = cyc;
    apply_stimulus(4'b1100, 1'b0);
    wait_done(15);
    check_output("t3_starve_cycles", cyc - gcyc, 8);
    check_output("t3_no_reads", rd_count - mark, 0);
    wait_grant(4'b1000, 5);
    apply_stimulus('0, 1'b0);
    wait_done(3);

    // Requester 1 drops its request after 2 reads.
    mark = rd_count;
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    push_exp(2'd1, 8'hC0);
    push_exp(2'd1, 8'hC1);
    apply_stimulus(4'b0010, 1'b0);
    wait_grant(4'b0010, 5);
    check_output("t4_r_en_first", int'(r_en), 1);
    step();
    step();
    apply_stimulus('0, 1'b0);
    #1;
    check_output("t4_no_third_r_en", int'(r_en), 0);
    step();
    check_output("t4_burst_done", int'(burst_done), 1);
    check_output("t4_reads", rd_count - mark, 2);
    // Pointer has moved past 1, so requester 0 now wins over 1.
    apply_stimulus(4'b0011, 1'b0);
    push_exp(2'd0, 8'hC2);
    push_exp(2'd0, 8'hC3);
    wait_grant(4'b0001, 5);
    apply_stimulus(4'b0001, 1'b0);
    wait_done(20);
    apply_stimulus('0, 1'b0);

    // Empty flag toggling 1,0,1,0 during a burst to requester 2.
    mark = rd_count;
    for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i));
    for (int i = 0; i < 4; i++) push_exp(2'd2, 8'hD0 + 8'(i));
    apply_stimulus(4'b0100, 1'b1);
    wait_grant(4'b0100, 5);
    for (int i = 0; i < 8; i++) begin
      force_empty = ((i % 2) == 0);
      #1;
      check_output("t5_r_en_pattern", int'(r_en), int'(!force_empty));
      step();
    end
    check_output("t5_burst_done", int'(burst_done), 1);
    check_output("t5_reads", rd_count - mark, 4);
    apply_stimulus('0, 1'b0);
    step();

    // Reset in the middle of a burst, one cycle after a read.
    for (int i = 0; i < 4; i++) push_word(8'hE0 + 8'(i));
    push_exp(2'd0, 8'hE0);
    apply_stimulus(4'b0001, 1'b0);
    wait_grant(4'b0001, 5);
    step();
    rst = 1'b1;
    #1;
    check_output("t6_r_en_in_reset", int'(r_en), 0);
    step();
    check_output("t6_grant", int'(grant), 0);
    check_output("t6_out_valid", int'(out_valid), 0);
    check_output("t6_out_id", int'(out_id), 0);
    check_output("t6_out_data", int'(out_data), 0);
    check_output("t6_burst_done", int'(burst_done), 0);
    rst = 1'b0;
    apply_stimulus(4'b1111, 1'b0);
    wait_grant(4'b0001, 5);
    apply_stimulus('0, 1'b0);
    wait_done(3);
    step();
    step();
    step();
    check_output("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
